// File: rtl/decode_if.sv
// Stream interface for the ByteDecode_d engine: 64-bit byte words in, four 16-bit
// coefficient lanes out.
interface decode_if;
  logic [63:0] i_ibytes;
  logic        i_ibytes_valid;
  logic [3:0]  i_l;
  logic        o_ibytes_ready;
  logic [63:0] o_coeffs;
  logic        o_coeffs_valid;
  logic        o_done;

  modport master (
    output i_ibytes, i_ibytes_valid, i_l,
    input  o_ibytes_ready, o_coeffs, o_coeffs_valid, o_done
  );

  modport slave (
    input  i_ibytes, i_ibytes_valid, i_l,
    output o_ibytes_ready, o_coeffs, o_coeffs_valid, o_done
  );
endinterface

// File: rtl/decode.sv
// ML-KEM ByteDecode_d: unpacks 32*d stream bytes into 256 d-bit coefficients,
// four per beat, with the d = 12 mod-q conditional subtract.
module decode (
  input logic     i_clk,
  input logic     i_rstn,
  decode_if.slave bus
);
  localparam logic [1:0]  StIdle = 2'd0;
  localparam logic [1:0]  StRun  = 2'd1;
  localparam logic [1:0]  StDone = 2'd2;
  localparam logic [11:0] Q      = 12'd3329;

  logic [1:0]   state_q, state_d;
  logic [3:0]   d_q, d_d, l_eff;
  logic [127:0] buf_q, buf_d, buf_shift, word_ext;
  logic [6:0]   fill_q, fill_d, fill_shift;
  logic [5:0]   words_q, words_d, quad;
  logic [6:0]   beats_q, beats_d;
  logic [63:0]  coeffs_q, coeffs_d, lanes, word_bits;
  logic         valid_q, valid_d, live_q;
  logic         ready, accept, extract;
  logic [11:0]  mask, raw;

  assign l_eff = (bus.i_l == 4'd0 || bus.i_l > 4'd12) ? 4'd12 : bus.i_l;
  assign quad  = {d_q, 2'b00};
  assign mask  = ~(12'hfff << d_q);

  // Byte 0 of the word lands in the low byte, so buffer bit k is stream bit k
  // (LSB-first within each byte).
  always_comb begin
    word_bits = '0;
    for (int b = 0; b < 8; b++) begin
      word_bits[8*b +: 8] = bus.i_ibytes[63-8*b -: 8];
    end
  end
  assign word_ext = {64'b0, word_bits};

  // live_q holds ready low until the first edge after reset release.
  assign ready   = live_q && (state_q == StIdle ||
                   (state_q == StRun && words_q < quad && fill_q <= 7'd64));
  assign accept  = bus.i_ibytes_valid && ready;
  assign extract = (state_q == StRun) && (beats_q != 7'd64) && (fill_q >= {1'b0, quad});

  always_comb begin
    lanes = '0;
    raw   = '0;
    for (int j = 0; j < 4; j++) begin
      raw = 12'(buf_q >> (6'(j) * {2'b00, d_q})) & mask;
      if (d_q == 4'd12 && raw >= Q) raw = raw - Q;
      lanes[16*j +: 16] = {4'b0, raw};
    end
  end

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    buf_d      = buf_q;
    fill_d     = fill_q;
    words_d    = words_q;
    beats_d    = beats_q;
    coeffs_d   = coeffs_q;
    valid_d    = 1'b0;
    buf_shift  = buf_q;
    fill_shift = fill_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          d_d     = l_eff;
          buf_d   = word_ext;
          fill_d  = 7'd64;
          words_d = 6'd1;
          beats_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // One idle cycle after beat 64 lets o_done trail the final valid beat.
        if (beats_q == 7'd64) state_d = StDone;
        if (extract) begin
          coeffs_d   = lanes;
          valid_d    = 1'b1;
          buf_shift  = buf_q >> quad;
          fill_shift = fill_q - {1'b0, quad};
          beats_d    = beats_q + 7'd1;
        end
        if (accept) begin
          buf_d   = buf_shift | (word_ext << fill_shift);
          fill_d  = fill_shift + 7'd64;
          words_d = words_q + 6'd1;
        end else begin
          buf_d  = buf_shift;
          fill_d = fill_shift;
        end
      end
      StDone: begin
        state_d = StIdle;
        buf_d   = '0;
        fill_d  = '0;
        words_d = '0;
        beats_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= StIdle;
      d_q      <= '0;
      buf_q    <= '0;
      fill_q   <= '0;
      words_q  <= '0;
      beats_q  <= '0;
      coeffs_q <= '0;
      valid_q  <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_q      <= d_d;
      buf_q    <= buf_d;
      fill_q   <= fill_d;
      words_q  <= words_d;
      beats_q  <= beats_d;
      coeffs_q <= coeffs_d;
      valid_q  <= valid_d;
      live_q   <= 1'b1;
    end
  end

  assign bus.o_ibytes_ready = ready;
  assign bus.o_coeffs       = coeffs_q;
  assign bus.o_coeffs_valid = valid_q;
  assign bus.o_done         = (state_q == StDone);
endmodule

// File: tb/tb_decode.sv
// Randomized bench for decode, checked against a bit-level ByteDecode_d model.
module tb_decode;
  logic i_clk = 1'b0;
  logic i_rstn;

  decode_if bus();

  decode u_dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  bytes_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int          done_cnt = 0;
  int          words_acc = 0;
  bit          timed_out = 1'b0;
  logic        prev_valid = 1'b0;
  logic [63:0] last_beat = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge i_clk) begin
    #1;
    if (bus.o_done) begin
      done_cnt++;
      check_eq("done_after_last_beat", 64'(prev_valid), 64'd1);
      check_eq("valid_low_at_done", 64'(bus.o_coeffs_valid), 64'd0);
      check_eq("coeffs_hold_at_done", bus.o_coeffs, last_beat);
      check_eq("ready_low_at_done", 64'(bus.o_ibytes_ready), 64'd0);
    end
    if (bus.o_coeffs_valid) begin
      got_q.push_back(bus.o_coeffs);
      last_beat = bus.o_coeffs;
    end
    prev_valid = bus.o_coeffs_valid;
  end

  task automatic fill_bytes(input int d, input int mode);
    logic [7:0] pat4 [4];
    logic [7:0] pat8 [8];
    pat4 = '{8'h21, 8'h43, 8'h65, 8'h87};
    pat8 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    bytes_q.delete();
    for (int i = 0; i < 32 * d; i++) begin
      case (mode)
        1:       bytes_q.push_back(8'hFF);
        2:       bytes_q.push_back(pat4[i % 4]);
        3:       bytes_q.push_back(pat8[i % 8]);
        default: bytes_q.push_back(8'($urandom));
      endcase
    end
  endtask

  // ByteDecode_d straight from the definition: coefficient i is stream bits i*d .. i*d+d-1.
  task automatic build_expect(input int d);
    exp_q.delete();
    for (int m = 0; m < 64; m++) begin
      logic [63:0] beat;
      beat = '0;
      for (int j = 0; j < 4; j++) begin
        int c;
        c = 0;
        for (int b = 0; b < d; b++) begin
          int k;
          k = (4 * m + j) * d + b;
          if (bytes_q[k / 8][k % 8]) c += (1 << b);
        end
        if (d == 12 && c >= 3329) c -= 3329;
        beat[16*j +: 16] = 16'(c);
      end
      exp_q.push_back(beat);
    end
  endtask

  task automatic run_poly(input int l, input int d, input int pct, input int abort_at);
    int          cyc;
    bit          rdy_checked;
    logic [63:0] w;
    cyc = 0;
    rdy_checked = 1'b0;
    got_q.delete();
    done_cnt  = 0;
    words_acc = 0;
    timed_out = 1'b0;
    while (1) begin
      @(negedge i_clk);
      if (bus.o_done) break;
      if (abort_at > 0 && words_acc == abort_at) break;
      if (cyc > 3000) begin
        timed_out = 1'b1;
        break;
      end
      cyc++;
      if (words_acc >= 4 * d && !rdy_checked) begin
        check_eq("ready_low_after_last_word", 64'(bus.o_ibytes_ready), 64'd0);
        rdy_checked = 1'b1;
      end
      if (words_acc < 4 * d) begin
        for (int b = 0; b < 8; b++) w[63-8*b -: 8] = bytes_q[8 * words_acc + b];
      end else begin
        w = {$urandom, $urandom};
      end
      bus.i_ibytes       = w;
      bus.i_l            = 4'(l);
      // Keep valid high past the last word to prove extra words are refused.
      bus.i_ibytes_valid = ($urandom_range(99) < pct) || (words_acc >= 4 * d);
      if (bus.i_ibytes_valid && bus.o_ibytes_ready) words_acc++;
    end
    bus.i_ibytes_valid = 1'b0;
    if (abort_at == 0) begin
      check_eq("timeout", 64'(timed_out), 64'd0);
      check_eq("words_consumed", 64'(words_acc), 64'(4 * d));
      check_eq("beat_count", 64'(got_q.size()), 64'd64);
      check_eq("done_count", 64'(done_cnt), 64'd1);
      for (int m = 0; m < 64; m++) begin
        if (m < got_q.size()) check_eq($sformatf("d%0d_beat%0d", d, m), got_q[m], exp_q[m]);
      end
    end
  endtask

  task automatic run_and_check(input int l, input int d, input int mode, input int pct);
    fill_bytes(d, mode);
    build_expect(d);
    run_poly(l, d, pct, 0);
  endtask

  initial begin
    i_rstn             = 1'b0;
    bus.i_ibytes       = '0;
    bus.i_ibytes_valid = 1'b0;
    bus.i_l            = '0;
    #3;
    check_eq("rst_coeffs", bus.o_coeffs, 64'd0);
    check_eq("rst_valid", 64'(bus.o_coeffs_valid), 64'd0);
    check_eq("rst_done", 64'(bus.o_done), 64'd0);
    check_eq("rst_ready", 64'(bus.o_ibytes_ready), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    #1;
    check_eq("ready_before_first_edge", 64'(bus.o_ibytes_ready), 64'd0);
    @(posedge i_clk);
    #1;
    check_eq("ready_after_first_edge", 64'(bus.o_ibytes_ready), 64'd1);

    run_and_check(1, 1, 1, 100);
    run_and_check(4, 4, 2, 100);
    check_eq("d4_first_beat", got_q.size() > 0 ? got_q[0] : '0, 64'h0004_0003_0002_0001);
    check_eq("d4_second_beat", got_q.size() > 1 ? got_q[1] : '0, 64'h0008_0007_0006_0005);
    run_and_check(12, 12, 3, 100);
    check_eq("d12_coeff0", got_q.size() > 0 ? 64'(got_q[0][15:0]) : '0, 64'h301);
    check_eq("d12_coeff1", got_q.size() > 0 ? 64'(got_q[0][31:16]) : '0, 64'h452);
    run_and_check(12, 12, 1, 100);
    check_eq("d12_ff_beat", got_q.size() > 0 ? got_q[63 % got_q.size()] : '0,
             64'h02FE_02FE_02FE_02FE);
    run_and_check(10, 10, 0, 50);
    run_and_check(0, 12, 0, 70);
    run_and_check(15, 12, 0, 40);

    // Abort a d=12 polynomial after 10 words.
    fill_bytes(12, 0);
    run_poly(12, 12, 100, 10);
    i_rstn = 1'b0;
    #1;
    check_eq("abort_coeffs", bus.o_coeffs, 64'd0);
    check_eq("abort_valid", 64'(bus.o_coeffs_valid), 64'd0);
    check_eq("abort_done", 64'(bus.o_done), 64'd0);
    check_eq("abort_ready", 64'(bus.o_ibytes_ready), 64'd0);
    done_cnt = 0;
    repeat (3) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (20) @(negedge i_clk);
    check_eq("abort_no_done", 64'(done_cnt), 64'd0);
    run_and_check(5, 5, 0, 80);

    // Back-to-back: the second starts right after the first's done cycle.
    run_and_check(11, 11, 0, 100);
    run_and_check(3, 3, 0, 100);

    repeat (4) begin
      int d;
      d = $urandom_range(1, 12);
      run_and_check(d, d, 0, $urandom_range(30, 100));
    end

    repeat (3) @(negedge i_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode.md
# decode

Kyber/ML-KEM ByteDecode_d engine. It consumes the 32·d-byte serialized form of one polynomial as a stream of 64-bit words. It produces the 256 d-bit coefficients, four per output beat. It sits between the byte-stream/key-unpacking path and the polynomial arithmetic datapath. For d = 12, coefficients are reduced mod q = 3329.

## Interface
- No parameters. Constants: N = 256 coefficients, q = 3329, input word 64 bits, output 4 lanes × 16 bits.
- Clocking/reset: one clock; reset is asynchronous and active-low.
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_ibytes  in  64  input word; stream byte 8k+b sits in bits [63-8b -: 8] of word k.
- i_ibytes_valid  in  1  input word valid.
- i_l  in  4  coefficient width d (1..12). Values 0 and 13..15 are treated as 12. Sampled on the first accepted word of a polynomial.
- o_ibytes_ready  out  1  DUT can accept a word this cycle.
- o_coeffs  out  64  four coefficients, zero-extended to 16 bits. Coefficient 4m+j is in bits [16j+15:16j].
- o_coeffs_valid  out  1  o_coeffs carries a new beat this cycle.
- o_done  out  1  one-cycle pulse after the 64th output beat of a polynomial.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- **IDLE**
  - ready = 1.
  - The first handshake (valid & ready) latches d from i_l, loads the word, and moves to RUN.
- **RUN: input side**
  - Words are accepted while the accepted-word count < 4d and buffer fill ≤ 64.
  - After 4d words, ready = 0 for the rest of the polynomial.
  - Input words arriving beyond 4d are not accepted.
- **Bit buffer:** 128-bit shift buffer with a 7-bit fill counter.
  - Each word's bytes are appended in stream order.
  - Within each byte, bits are taken LSB-first, per FIPS 203 BytesToBits.
  - Coefficient i = stream bits [i·d .. i·d+d-1], with bit i·d as the coefficient LSB.
- **RUN: output side**
  - Whenever fill ≥ 4d, the DUT extracts 4 coefficients, removes 4d bits, and asserts o_coeffs_valid.
  - There is no output backpressure.
  - In the same cycle, fill_next = fill − 4d·out + 64·in; this never exceeds 128.
- **d = 12 reduction:** each coefficient c ≥ 3329 is replaced by c − 3329 (one conditional subtract). No reduction is applied for d < 12.
- **DONE**
  - Entered after output beat 64.
  - o_done = 1 for one cycle, ready = 0.
  - Then IDLE, with counters and fill cleared.
- **Output hold:** o_coeffs holds its last value while o_coeffs_valid = 0, including after DONE.

## Timing
- **Reset values:** o_coeffs = 0, o_coeffs_valid = 0, o_done = 0, o_ibytes_ready = 0.
  - o_ibytes_ready rises on the first rising edge after i_rstn deasserts.
- **Reset mid-polynomial:** aborts immediately. No o_done is produced; the buffer and counters clear.
- **Latency:** a word accepted at edge n can yield its first output beat at edge n+1 (registered outputs).
- **Throughput:** one word/cycle in, one beat/cycle out.
  - A polynomial takes at least max(4d, 64) + 2 cycles.
  - d = 12 needs 48 words for 64 beats. d = 1 needs 4 words; its output then drains at 1 beat/cycle.
- **o_done timing:** asserted the cycle after the final o_coeffs_valid, which keeps the last beat's value on o_coeffs.
- **Simultaneous events:** accept and extract in the same cycle are both performed.
- **Back-to-back polynomials:** a new polynomial may start in the cycle after DONE.

## Test plan
- d=1, 4 words 0xFFFF_FFFF_FFFF_FFFF → 64 beats of 0x0001_0001_0001_0001, then an o_done pulse; ready low after the 4th word.
- d=4, stream bytes 0x21,0x43,0x65,0x87,… → first beat 0x0004_0003_0002_0001, second beat 0x0008_0007_0006_0005.
- d=12, stream bytes 0x01,0x23,0x45,… → coeff0 = 0x301, coeff1 = 0x452. An all-0xFF stream (48 words) gives every lane 0x02FE (4095 − 3329 = 766).
- Valid toggled randomly with d=10, compared against a software ByteDecode_10 → identical 256 coefficients, 40 words consumed, exactly 64 valid beats.
- i_rstn pulsed low mid-polynomial (after 10 words, d=12) → all outputs 0 immediately, no o_done. A fresh d=5 polynomial afterwards decodes correctly.
- Two polynomials back-to-back (d=11 then d=3) → the second uses the newly sampled d, with 44 and 12 words consumed respectively.
